pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Instruction-fetch front end. Sits directly upstream of the 16-bit instruction memory (128 words, registered read, word-addressed).
- Owns the program counter and drives the memory read address.
- Tags the instruction that returns one cycle later with its PC and a valid bit, and presents it to decode.
- Handles stall, branch/jump redirect, a halt opcode and an instruction counter.

Parameters:
- PC_WIDTH, 16, width of the PC and of the memory address.
- RESET_PC, 16'h0000, first fetch address after reset.
- MEM_DEPTH, 128, number of instruction words; used only by the optional bounds check.
- HALT_WORD, 16'hFFFF, instruction encoding that halts fetch.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  downstream hold: freeze PC and the current instruction.
- branch_taken  in  1  relative redirect request from decode.
- branch_off  in  8  signed word offset for the branch.
- jump  in  1  absolute redirect request from decode.
- jump_target  in  PC_WIDTH  absolute jump address.
- instr_in  in  16  registered data output of the instruction memory.
- pc_out  out  PC_WIDTH  read address to the instruction memory.
- if_instr  out  16  instruction to decode; combinational copy of instr_in.
- if_pc  out  PC_WIDTH  address of if_instr.
- if_valid  out  1  if_instr/if_pc are valid.
- halted  out  1  fetch stopped by HALT_WORD.
- fault  out  1  out-of-range fetch; always 0 unless BOUNDS_CHECK_EN is defined.
- instr_count  out  16  number of accepted instructions.

Behaviour:
- Registers:
  - pc_q: next address to issue.
  - pend_pc, pend_valid: the address the memory sampled at the last edge.
  - state: RUN, HALT or FAULT.
  - instr_count.
- Reset values (synchronous; a reset mid-operation overrides every other input at that edge):
  - pc_q = pend_pc = RESET_PC, pend_valid = 0, state = RUN, instr_count = 0.
  - Outputs during and after reset: pc_out = RESET_PC, if_valid = 0, halted = 0, fault = 0.
  - The external memory output is not reset; if_valid = 0 masks it.
- Timing: the memory samples pc_out at edge k; instr_in carries mem[pc_out] after edge k. Therefore if_instr = instr_in, if_pc = pend_pc, if_valid = pend_valid && state == RUN.
- First instruction: if_valid rises 1 cycle after reset deasserts, with if_pc = RESET_PC.
- Per-cycle priority in RUN: reset > stall > halt detect > jump > branch_taken > sequential.
  - Stall: pc_out = pend_pc, so the memory re-reads the same word and instr_in stays stable. pc_q, pend_pc, pend_valid and instr_count all hold. Redirects are ignored; decode must hold them until stall drops.
  - Halt detect (if_valid && if_instr == HALT_WORD, stall = 0): next state is HALT; instr_count increments once for the halt word. A redirect in the same cycle is ignored.
  - Jump (requires if_valid = 1): target T = jump_target.
  - Branch (requires if_valid = 1, jump = 0): T = if_pc + 1 + sign_extend(branch_off), modulo 2^PC_WIDTH.
  - Redirect action: pc_out = T combinationally in the same cycle; at the edge pend_pc <= T, pend_valid <= 1, pc_q <= T + 1. The wrong-path address in pc_q is never issued, so the redirect has zero bubbles.
  - Redirects with if_valid = 0 are ignored.
  - Sequential: pc_out = pc_q; at the edge pend_pc <= pc_q, pend_valid <= 1, pc_q <= pc_q + 1.
  - PC wraps from 2^PC_WIDTH-1 to 0 when BOUNDS_CHECK_EN is undefined.
- instr_count: +1 at each edge with if_valid = 1 and stall = 0. Wraps from 16'hFFFF to 0.
- HALT:
  - pc_out = pend_pc (the halt address); all registers frozen.
  - if_valid = 0, halted = 1.
  - stall, jump and branch are ignored. Exit only via reset.
- FAULT: see the optional feature below.

Optional Feature:
- Macro: BOUNDS_CHECK_EN.
- Defined:
  - Any address that would be issued (sequential, branch or jump) with value >= MEM_DEPTH is not issued.
  - pc_out instead holds pend_pc; the next state is FAULT.
  - FAULT: fault = 1, if_valid = 0, all registers frozen, exit only via reset.
  - The check is evaluated only in non-stall cycles.
- Undefined: no check is performed, fault is tied to 0, and the full PC_WIDTH address is driven.

Test Plan:
- Reset 3 cycles, then release, memory words 0..4 = 1000..1004, no stall -> if_valid = 0 for 1 cycle, then if_pc 0,1,2,3 with if_instr 1000,1001,1002,1003 on consecutive cycles; instr_count = 4 after 4 accepted.
- stall = 1 for 3 cycles while if_pc = 2 -> if_pc = 2 and if_instr = 1002 stable; pc_out = 2; instr_count unchanged. On release, if_pc = 3 on the next cycle.
- branch_taken with if_pc = 5, branch_off = 8'hFC (-4) -> pc_out = 2 in the same cycle, if_pc = 2 on the next cycle, then 3. Jump with jump_target = 16'h0040 while branch_taken = 1 -> jump wins, next if_pc = 16'h0040.
- Memory word 6 = 16'hFFFF -> halted = 1 one cycle after if_pc = 6 is presented; if_valid = 0; pc_out = 6 and stays there despite jump pulses. Reset restarts at RESET_PC.
- Reset asserted mid-run at if_pc = 9 -> next cycle if_valid = 0, instr_count = 0, pc_out = 0.
- BOUNDS_CHECK_EN defined, jump_target = 16'd128 -> fault = 1 next cycle, if_valid = 0, pc_out unchanged. Without the macro, the same stimulus gives pc_out = 128 and fault = 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end. It owns the PC and drives the
// memory read address. It also tags each returned word with its PC and valid.
// Ports:
//   in:  clk, reset (sync, active-high), stall, branch_taken, branch_off[7:0],
//        jump, jump_target, instr_in[15:0]
//   out: pc_out, if_instr, if_pc, if_valid, halted, fault, instr_count[15:0]
// Optional macro BOUNDS_CHECK_EN: never issue addresses >= MEM_DEPTH; fault.
module pc_fetch_unit #(
  parameter int unsigned         PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned         MEM_DEPTH = 128,
  parameter logic [15:0]         HALT_WORD = 16'hFFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [7:0]          branch_off,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic [15:0]         instr_in,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [15:0]         if_instr,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic                if_valid,
  output logic                halted,
  output logic                fault,
  output logic [15:0]         instr_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } state_t;

`ifdef BOUNDS_CHECK_EN
  localparam bit LP_CHK = 1'b1;
`else
  localparam bit LP_CHK = 1'b0;
`endif

  localparam logic [PC_WIDTH:0] LP_DEPTH =
    (PC_WIDTH+1)'(MEM_DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc_q;
  logic [PC_WIDTH-1:0] w_pc_q_nxt;
  logic [PC_WIDTH-1:0] r_pend_pc;
  logic [PC_WIDTH-1:0] w_pend_pc_nxt;
  logic                r_pend_valid;
  logic                w_pend_valid_nxt;
  logic [15:0]         r_icnt;
  logic [15:0]         w_icnt_nxt;
  logic [PC_WIDTH-1:0] w_br_tgt;
  logic [PC_WIDTH-1:0] w_tgt;
  logic [PC_WIDTH-1:0] w_pc_out;
  logic                w_if_valid;
  logic                w_halt_det;
  logic                w_oob;

  assign w_if_valid = r_pend_valid &&
                      (r_state == ST_RUN);
  assign w_halt_det = w_if_valid &&
                      (instr_in == HALT_WORD);

  assign w_br_tgt = r_pend_pc + PC_WIDTH'(1) +
    {{(PC_WIDTH-8){branch_off[7]}}, branch_off};

  // Address to issue this cycle if nothing
  // blocks it: jump beats branch beats pc_q.
  always_comb begin
    w_tgt = r_pc_q;
    if (w_if_valid && jump)
      w_tgt = jump_target;
    else if (w_if_valid && branch_taken)
      w_tgt = w_br_tgt;
  end

  assign w_oob = LP_CHK &&
    ({1'b0, w_tgt} >= LP_DEPTH);

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_q_nxt       = r_pc_q;
    w_pend_pc_nxt    = r_pend_pc;
    w_pend_valid_nxt = r_pend_valid;
    w_icnt_nxt       = r_icnt;
    // Re-reading pend_pc keeps instr_in stable
    // whenever nothing new is issued.
    w_pc_out         = r_pend_pc;
    unique case (r_state)
      ST_RUN: begin
        if (!stall) begin
          if (w_if_valid)
            w_icnt_nxt = r_icnt + 16'd1;
          if (w_halt_det) begin
            w_state_nxt = ST_HALT;
          end else if (w_oob) begin
            w_state_nxt = ST_FAULT;
          end else begin
            w_pc_out         = w_tgt;
            w_pend_pc_nxt    = w_tgt;
            w_pend_valid_nxt = 1'b1;
            w_pc_q_nxt       = w_tgt + PC_WIDTH'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_pc_q       <= RESET_PC;
      r_pend_pc    <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_icnt       <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc_q       <= w_pc_q_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_icnt       <= w_icnt_nxt;
    end
  end

  // Reset forces the visible outputs even
  // before the first reset edge lands.
  assign pc_out      = reset ? RESET_PC : w_pc_out;
  assign if_instr    = instr_in;
  assign if_pc       = r_pend_pc;
  assign if_valid    = w_if_valid && !reset;
  assign halted      = (r_state == ST_HALT) && !reset;
  assign fault       = (r_state == ST_FAULT) && !reset;
  assign instr_count = r_icnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vectors for pc_fetch_unit
// with a registered 128-word instruction memory model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_off;
  logic        jump;
  logic [15:0] jump_target;
  logic [15:0] instr_in;
  logic [15:0] pc_out;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  logic [15:0] mem [0:127];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    instr_in <= mem[pc_out[6:0]];

  pc_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump         (jump),
    .jump_target  (jump_target),
    .instr_in     (instr_in),
    .pc_out       (pc_out),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_valid     (if_valid),
    .halted       (halted),
    .fault        (fault),
    .instr_count  (instr_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++)
      mem[i] = 16'(1000 + i);
    mem[6] = 16'hFFFF;
    reset        = 1'b1;
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_off   = 8'h00;
    jump         = 1'b0;
    jump_target  = 16'h0000;

    repeat (3) tick();
    chk("rst_pc", pc_out, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cnt", instr_count, 0);

    reset = 1'b0;
    #1;
    chk("rel_valid", if_valid, 0);
    chk("rel_pc", pc_out, 0);

    for (int k = 0; k < 3; k++) begin
      tick();
      chk("seq_valid", if_valid, 1);
      chk("seq_ifpc", if_pc, k);
      chk("seq_instr", if_instr, 1000 + k);
      chk("seq_cnt", instr_count, k);
    end

    stall       = 1'b1;
    jump        = 1'b1;
    jump_target = 16'h0030;
    #1;
    chk("stl_pcout", pc_out, 2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stl_ifpc", if_pc, 2);
      chk("stl_instr", if_instr, 1002);
      chk("stl_pcout", pc_out, 2);
      chk("stl_cnt", instr_count, 2);
    end
    stall = 1'b0;
    jump  = 1'b0;
    #1;
    chk("unstl_pcout", pc_out, 3);
    for (int k = 3; k < 6; k++) begin
      tick();
      chk("post_ifpc", if_pc, k);
      chk("post_instr", if_instr, 1000 + k);
      chk("post_cnt", instr_count, k);
    end

    branch_taken = 1'b1;
    branch_off   = 8'hFC;
    #1;
    chk("br_pcout", pc_out, 2);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("br_ifpc", if_pc, 2);
    chk("br_instr", if_instr, 1002);
    chk("br_cnt", instr_count, 6);
    tick();
    chk("br_ifpc2", if_pc, 3);

    jump         = 1'b1;
    jump_target  = 16'h0040;
    branch_taken = 1'b1;
    #1;
    chk("jmp_pcout", pc_out, 16'h0040);
    tick();
    branch_taken = 1'b0;
    jump_target  = 16'h0006;
    #1;
    chk("jmp_ifpc", if_pc, 16'h0040);
    chk("jmp_instr", if_instr, 1064);
    chk("jmp6_pcout", pc_out, 6);
    tick();
    jump_target = 16'h0020;
    #1;
    chk("hd_ifpc", if_pc, 6);
    chk("hd_valid", if_valid, 1);
    chk("hd_halted", halted, 0);
    chk("hd_pcout", pc_out, 6);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hlt_halted", halted, 1);
      chk("hlt_valid", if_valid, 0);
      chk("hlt_pcout", pc_out, 6);
      chk("hlt_cnt", instr_count, 10);
    end

    jump  = 1'b0;
    reset = 1'b1;
    #1;
    chk("hrst_pcout", pc_out, 0);
    chk("hrst_halted", halted, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rs_valid", if_valid, 0);
    tick();
    chk("rs_ifpc", if_pc, 0);
    chk("rs_instr", if_instr, 1000);
    jump        = 1'b1;
    jump_target = 16'h0008;
    #1;
    chk("rs_jpc", pc_out, 8);
    tick();
    jump = 1'b0;
    tick();
    chk("mid_ifpc", if_pc, 9);
    chk("mid_cnt", instr_count, 2);
    reset = 1'b1;
    tick();
    chk("mid_valid", if_valid, 0);
    chk("mid_cnt0", instr_count, 0);
    chk("mid_pcout", pc_out, 0);

    reset = 1'b0;
    tick();
    chk("bc_ifpc", if_pc, 0);
    jump        = 1'b1;
    jump_target = 16'd128;
    #1;
`ifdef BOUNDS_CHECK_EN
    chk("bc_pcout", pc_out, 0);
    tick();
    jump = 1'b0;
    #1;
    chk("bc_fault", fault, 1);
    chk("bc_valid", if_valid, 0);
    chk("bc_pcout2", pc_out, 0);
`else
    chk("bc_pcout", pc_out, 128);
    tick();
    jump = 1'b0;
    #1;
    chk("bc_fault", fault, 0);
    chk("bc_valid", if_valid, 1);
    chk("bc_ifpc2", if_pc, 128);
`endif
    chk("bc_cnt", instr_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
